// File: rtl/dco_cal_ctrl.sv
// rtl/dco_cal_ctrl.sv - SAR calibration controller for the DCO code; DCO_CAL_TRACK_EN adds post-lock tracking.
module dco_cal_ctrl #(
    parameter int EDGES   = 4,
    parameter int SETTLE  = 64,
    parameter int TIMEOUT = 1023,
    parameter int CW      = 12,
    parameter int TOL     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] target,
    input  logic          dco_out,
    output logic [7:0]    dco_code,
    output logic          dco_en,
    output logic          busy,
    output logic          done,
    output logic          locked,
    output logic [CW-1:0] meas,
    output logic          timeout
);

    localparam int            IW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT - 1);
    localparam logic [3:0]    EDGE_LAST   = 4'(EDGES - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [CW:0]   TOL_W       = (CW + 1)'(TOL);

`ifdef DCO_CAL_TRACK_EN
    localparam bit TRACK_EN = 1'b1;
`else
    localparam bit TRACK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SYNC, S_MEAS, S_DECIDE, S_VERIFY, S_DONE
    } state_t;

    // Which pass the shared SETTLE/SYNC/MEAS sequence belongs to.
    typedef enum logic [1:0] {M_SAR, M_VFY, M_TRK} mode_t;

    state_t        state, state_n;
    mode_t         mode, mode_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    code_n, trial;
    logic          en_n, busy_n, done_n, locked_n, timeout_n;
    logic [CW-1:0] meas_n, cnt, cnt_n, cnt_inc;
    logic [3:0]    edge_cnt, edge_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic          dco_q, toggle, begin_cal, timeout_hit;
    state_t        meas_exit;

    assign toggle    = dco_out ^ dco_q;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign meas_exit = (mode == M_SAR) ? S_DECIDE : S_VERIFY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            mode     <= M_SAR;
            bit_idx  <= 3'd7;
            dco_code <= 8'h00;
            dco_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            locked   <= 1'b0;
            meas     <= '0;
            timeout  <= 1'b0;
            cnt      <= '0;
            edge_cnt <= '0;
            idle_cnt <= '0;
            dco_q    <= 1'b0;
        end else begin
            state    <= state_n;
            mode     <= mode_n;
            bit_idx  <= bit_n;
            dco_code <= code_n;
            dco_en   <= en_n;
            busy     <= busy_n;
            done     <= done_n;
            locked   <= locked_n;
            meas     <= meas_n;
            timeout  <= timeout_n;
            cnt      <= cnt_n;
            edge_cnt <= edge_n;
            idle_cnt <= idle_n;
            dco_q    <= dco_out;
        end
    end

    always_comb begin
        state_n     = state;
        mode_n      = mode;
        bit_n       = bit_idx;
        code_n      = dco_code;
        en_n        = dco_en;
        busy_n      = busy;
        done_n      = done;
        locked_n    = locked;
        meas_n      = meas;
        timeout_n   = timeout;
        cnt_n       = cnt;
        edge_n      = edge_cnt;
        idle_n      = idle_cnt;
        trial       = dco_code;
        begin_cal   = 1'b0;
        timeout_hit = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    begin_cal = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    idle_n  = '0;
                    state_n = S_SYNC;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_SYNC: begin
                if (toggle) begin
                    cnt_n   = '0;
                    edge_n  = '0;
                    idle_n  = '0;
                    state_n = S_MEAS;
                end else if (idle_cnt == IDLE_LAST) begin
                    timeout_hit = 1'b1;
                end else begin
                    idle_n = idle_cnt + 1'b1;
                end
            end
            S_MEAS: begin
                cnt_n = cnt_inc;
                if (toggle) begin
                    idle_n = '0;
                    // cnt_inc on the closing toggle gives EDGES*H for half-period H.
                    if (edge_cnt == EDGE_LAST) begin
                        meas_n  = cnt_inc;
                        state_n = meas_exit;
                    end else begin
                        edge_n = edge_cnt + 1'b1;
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    timeout_hit = 1'b1;
                end else begin
                    idle_n = idle_cnt + 1'b1;
                end
            end
            S_DECIDE: begin
                if (meas > target) begin
                    trial[bit_idx] = 1'b0;
                end
                if (bit_idx != 3'd0) begin
                    trial[bit_idx - 3'd1] = 1'b1;
                    bit_n = bit_idx - 3'd1;
                end else begin
                    mode_n = M_VFY;
                end
                code_n  = trial;
                cnt_n   = '0;
                state_n = S_SETTLE;
            end
            S_VERIFY: begin
                if (TRACK_EN && mode == M_TRK) begin
                    if (meas > target && dco_code != 8'h00) begin
                        code_n   = dco_code - 8'd1;
                        locked_n = 1'b0;
                    end else if (({1'b0, meas} + TOL_W) < {1'b0, target} && dco_code != 8'hFF) begin
                        code_n = dco_code + 8'd1;
                    end else begin
                        locked_n = 1'b1;
                    end
                end else begin
                    locked_n = (meas <= target);
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                end
                state_n = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    begin_cal = 1'b1;
                end else if (TRACK_EN) begin
                    mode_n  = M_TRK;
                    cnt_n   = '0;
                    state_n = S_SETTLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (timeout_hit) begin
            meas_n    = CNT_MAX;
            timeout_n = 1'b1;
            state_n   = meas_exit;
        end

        if (begin_cal) begin
            busy_n    = 1'b1;
            en_n      = 1'b1;
            done_n    = 1'b0;
            timeout_n = 1'b0;
            locked_n  = 1'b0;
            code_n    = 8'h80;
            bit_n     = 3'd7;
            mode_n    = M_SAR;
            cnt_n     = '0;
            state_n   = S_SETTLE;
        end
    end

endmodule

// File: tb/tb_dco_cal_ctrl.sv
// tb/tb_dco_cal_ctrl.sv - scoreboard bench for dco_cal_ctrl with a code-dependent DCO model.
module tb_dco_cal_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] target;
    logic        dco_out = 1'b0;
    logic [7:0]  dco_code;
    logic        dco_en;
    logic        busy;
    logic        done;
    logic        locked;
    logic [11:0] meas;
    logic        timeout;

    logic        dco_stuck = 1'b0;
    int          hc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  prev_code = 8'h00;

    typedef struct packed {
        logic [7:0]  code;
        logic [11:0] meas;
        logic        locked;
        logic        to;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] trial_q[$];

    dco_cal_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .target   (target),
        .dco_out  (dco_out),
        .dco_code (dco_code),
        .dco_en   (dco_en),
        .busy     (busy),
        .done     (done),
        .locked   (locked),
        .meas     (meas),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    function automatic int half_of(input logic [7:0] c);
        if (c == 8'h00) return 51;
        else if (c == 8'h01) return 4;
        else if (c < 8'h04) return 5;
        else if (c < 8'h08) return 6;
        else if (c < 8'h10) return 7;
        else if (c < 8'h20) return 8;
        else if (c < 8'h40) return 9;
        else if (c < 8'h80) return 10;
        else return 11;
    endfunction

    always @(negedge clk) begin
        if (!dco_en || dco_stuck) begin
            dco_out = 1'b0;
            hc = 0;
        end else if (hc >= half_of(dco_code) - 1) begin
            dco_out = ~dco_out;
            hc = 0;
        end else begin
            hc = hc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each code the controller presents while busy is compared against the expected trial order.
    always begin
        @(posedge clk);
        #1;
        if (busy && dco_code != prev_code && trial_q.size() > 0)
            check_eq("trial_code", {24'd0, dco_code}, {24'd0, trial_q.pop_front()});
        prev_code = dco_code;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_halving(input int n);
        logic [7:0] c = 8'h80;
        for (int i = 0; i < n; i++) begin
            trial_q.push_back(c);
            c = c >> 1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_code"},    {24'd0, dco_code}, 32'h00);
        check_eq({tag, "_en"},      {31'd0, dco_en},   32'd0);
        check_eq({tag, "_busy"},    {31'd0, busy},     32'd0);
        check_eq({tag, "_done"},    {31'd0, done},     32'd0);
        check_eq({tag, "_locked"},  {31'd0, locked},   32'd0);
        check_eq({tag, "_meas"},    {20'd0, meas},     32'd0);
        check_eq({tag, "_timeout"}, {31'd0, timeout},  32'd0);
    endtask

    task automatic run_cal(input logic [11:0] tgt, input logic [7:0] e_code, input logic [11:0] e_meas,
                           input logic e_lock, input logic e_to, input bit mid_start);
        exp_t e;
        int   cyc;
        sb_q.push_back('{code: e_code, meas: e_meas, locked: e_lock, to: e_to});
        target = tgt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        check_eq("done_after_start", {31'd0, done}, 32'd0);
        cyc = 0;
        while (!done && cyc < 20000) begin
            tick();
            cyc++;
            start = (mid_start && cyc == 300) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check_eq("done_seen", {31'd0, done}, 32'd1);
        e = sb_q.pop_front();
        check_eq("final_code",    {24'd0, dco_code}, {24'd0, e.code});
        check_eq("final_meas",    {20'd0, meas},     {20'd0, e.meas});
        check_eq("final_locked",  {31'd0, locked},   {31'd0, e.locked});
        check_eq("final_timeout", {31'd0, timeout},  {31'd0, e.to});
        check_eq("final_busy",    {31'd0, busy},     32'd0);
        check_eq("final_en",      {31'd0, dco_en},   32'd1);
        check_eq("trials_left",   trial_q.size(),    32'd0);
        trial_q.delete();
        repeat (40) tick();
        check_eq("done_held", {31'd0, done},     32'd1);
        check_eq("code_held", {24'd0, dco_code}, {24'd0, e.code});
    endtask

    task automatic push_t30();
        trial_q.push_back(8'h80); trial_q.push_back(8'h40);
        trial_q.push_back(8'h20); trial_q.push_back(8'h10);
        trial_q.push_back(8'h08); trial_q.push_back(8'h0C);
        trial_q.push_back(8'h0E); trial_q.push_back(8'h0F);
    endtask

    initial begin
        int         cyc;
        logic [7:0] c;
        reset  = 1'b1;
        start  = 1'b0;
        target = 12'd0;
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        push_t30();
        run_cal(12'd30, 8'h0F, 12'd28, 1'b1, 1'b0, 1'b0);

        c = 8'h80;
        for (int i = 0; i < 8; i++) begin
            trial_q.push_back(c);
            c = {1'b1, c[7:1]};
        end
        run_cal(12'd50, 8'hFF, 12'd44, 1'b1, 1'b0, 1'b1);

        push_halving(9);
        run_cal(12'd10, 8'h00, 12'd204, 1'b0, 1'b0, 1'b0);

        dco_stuck = 1'b1;
        push_halving(9);
        run_cal(12'd30, 8'h00, 12'hFFF, 1'b0, 1'b1, 1'b0);
        dco_stuck = 1'b0;

        // Interrupt the third SAR pass during its measurement window.
        target = 12'd30;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cyc = 0;
        while (dco_code != 8'h20 && cyc < 5000) begin
            tick();
            cyc++;
        end
        check_eq("reached_third_trial", {24'd0, dco_code}, 32'h20);
        repeat (82) tick();
        check_eq("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check_reset_values("mid_rst");
        reset = 1'b0;
        tick();

        push_t30();
        run_cal(12'd30, 8'h0F, 12'd28, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
